sp_ram_arbiter: RTL and testbench
=================================

// Module: sp_ram_arbiter
// PURPOSE
//  Shares one Gowin_SP single-port RAM (32b x 16K) between two requesters: A (instruction fetch) and B (load/store).
//  Does 2-way round-robin arbitration, one RAM access per cycle, and routes read data back to the owner.
//  Sits directly in front of the Gowin_SP instance.
// PARAMETERS
//  AW      14  word address width (RAM ad)
//  DW      32  data width (RAM din/dout)
//  RD_LAT  1   RAM read latency in cycles: 1 = bypass mode, 2 = output-register mode; other values illegal
// PORTS
//  clk        in   1   single clock; RAM runs on the same clock
//  reset_n    in   1   asynchronous, active-low reset
//  a_req      in   1   A access request; held until a_gnt
//  a_we       in   1   A write (1) / read (0)
//  a_addr     in   AW  A word address
//  a_wdata    in   DW  A write data
//  a_gnt      out  1   A granted this cycle (combinational)
//  a_rvalid   out  1   A read data valid
//  a_rdata    out  DW  A read data
//  b_*        -    -   same seven ports for requester B
//  ram_ce     out  1   RAM clock enable
//  ram_oce    out  1   RAM output-register enable; tied 1
//  ram_reset  out  1   RAM output reset = ~reset_n
//  ram_wre    out  1   RAM write enable
//  ram_ad     out  AW  RAM address
//  ram_din    out  DW  RAM write data
//  ram_dout   in   DW  RAM read data
// BEHAVIOUR
//  - Grant is combinational:
//    - only A requests -> a_gnt; only B requests -> b_gnt;
//    - both request -> grant the side not in register last_win;
//    - last_win updates on every grant. At most one gnt per cycle.
//  - last_win resets to B, so A wins the first conflict after reset.
//  - Under continuous conflict, grants strictly alternate; a requester waits at most 1 cycle.
//  - RAM drive: ram_ce = a_gnt|b_gnt. ram_wre/ram_ad/ram_din are muxed from the winner.
//    With no grant: ram_wre=0, ram_ad=0, ram_din=0.
//  - Read return uses a tag pipeline of RD_LAT stages {valid, owner}. It is loaded on each read grant (we=0).
//    Writes load valid=0.
//  - x_rvalid=1 exactly RD_LAT cycles after the read grant cycle, for the owner only.
//    a_rdata and b_rdata both = ram_dout, unregistered. Data is meaningful only with rvalid.
//  - Back-to-back reads (any owner mix) return in grant order, one per cycle, with no bubbles.
//  - Writes give no response; the grant cycle is the completion. A read granted after a write to the same
//    address returns the written data.
//  - Reset (async, any time):
//    - all tag stages clear; in-flight reads are dropped and never produce rvalid;
//    - a_gnt=b_gnt=0, rvalid=0, ram_ce=0, ram_wre=0 while reset_n=0.
//  - a_req/b_req deasserted without a grant are legal; nothing is issued.
// CONFIGURATION
//  Macro SP_ARB_STATS_EN:
//  - Defined: adds outputs stat_conflict[15:0] and stat_reads[15:0]. Both are saturating counters, reset to 0.
//    - stat_conflict counts cycles with a_req&b_req.
//    - stat_reads counts read grants.
//  - Undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  Package sp_arb_pkg:
//  - typedef enum logic {OWN_A, OWN_B} owner_e;
//  - typedef struct packed {logic valid; owner_e owner;} rd_tag_t;
//  - localparam STAT_W = 16.
//  Sub-module sp_arb_tag_pipe: RD_LAT-deep rd_tag_t shift register with async clear.
//  The grant logic stays in the top module.
// TESTING
//  1. B writes 0xDEADBEEF @0x0010, then A reads 0x0010 -> a_rvalid 1 cycle after a_gnt, a_rdata=0xDEADBEEF;
//     b_rvalid stays 0.
//  2. a_req=b_req=1 (reads) for 8 cycles after reset -> grants A,B,A,B,A,B,A,B; rvalid owners follow the same
//     order, 1 cycle later.
//  3. Only B issues reads to 0x1,0x2,0x3,0x4 (preloaded 0x11,0x22,0x33,0x44) -> b_gnt every cycle;
//     b_rdata 0x11..0x44 on 4 consecutive cycles.
//  4. reset_n low the cycle after an A read grant -> no a_rvalid ever appears for it; gnt/rvalid/ram_ce=0 during
//     reset; after release the first conflict goes to A.
//  5. RD_LAT=2 build, repeat test 1 -> a_rvalid exactly 2 cycles after a_gnt with 0xDEADBEEF.
//  6. SP_ARB_STATS_EN defined, 5 conflict read cycles -> stat_conflict=5, stat_reads=5.
//     Without the macro the build has no stat_* ports.

Source files
------------

// File: rtl/sp_arb_pkg.sv
// Shared types for the single-port RAM arbiter: read-tag layout, owner encoding
// and the saturating statistics counter helper.
package sp_arb_pkg;

  typedef enum logic {OWN_A = 1'b0, OWN_B = 1'b1} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sp_arb_tag_pipe.sv
// RD_LAT-deep shift register of read tags; the last stage lines up with the
// cycle in which the RAM presents the matching read data.
module sp_arb_tag_pipe
  import sp_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t tag_p [RD_LAT];

  // Asynchronous clear drops every in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tag_out = tag_p[RD_LAT-1];

endmodule

// File: rtl/sp_ram_arbiter.sv
// Two-way round-robin arbiter in front of a Gowin_SP single-port RAM.
// Optional macro SP_ARB_STATS_EN adds saturating conflict/read counters.
module sp_ram_arbiter
  import sp_arb_pkg::*;
#(
  parameter int AW     = 14,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_ce,
  output logic          ram_oce,
  output logic          ram_reset,
  output logic          ram_wre,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
`ifdef SP_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_conflict,
  output logic [STAT_W-1:0] stat_reads
`endif
);

  owner_e  last_win;
  logic    grant_a;
  logic    grant_b;
  rd_tag_t tag_in;
  rd_tag_t tag_out;

  // Grants are masked by reset_n so nothing reaches the RAM while in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n) begin
      if (a_req && b_req) begin
        grant_a = (last_win == OWN_B);
        grant_b = (last_win == OWN_A);
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     last_win <= OWN_B;
    else if (grant_a) last_win <= OWN_A;
    else if (grant_b) last_win <= OWN_B;
  end

  always_comb begin
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (grant_a) begin
      ram_wre = a_we;
      ram_ad  = a_addr;
      ram_din = a_wdata;
    end else if (grant_b) begin
      ram_wre = b_we;
      ram_ad  = b_addr;
      ram_din = b_wdata;
    end
  end

  assign ram_ce    = grant_a | grant_b;
  assign ram_oce   = 1'b1;
  assign ram_reset = ~reset_n;

  always_comb begin
    tag_in.valid = (grant_a && !a_we) || (grant_b && !b_we);
    tag_in.owner = grant_b ? OWN_B : OWN_A;
  end

  sp_arb_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign a_rvalid = tag_out.valid && (tag_out.owner == OWN_A);
  assign b_rvalid = tag_out.valid && (tag_out.owner == OWN_B);
  assign a_rdata  = ram_dout;
  assign b_rdata  = ram_dout;

`ifdef SP_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_conflict <= '0;
      stat_reads    <= '0;
    end else begin
      if (a_req && b_req) stat_conflict <= sat_inc(stat_conflict);
      if (tag_in.valid)   stat_reads    <= sat_inc(stat_reads);
    end
  end
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter with a behavioural Gowin_SP model and a
// read-return scoreboard. Set RD_LAT=2 to exercise output-register mode.
module tb_sp_ram_arbiter #(
  parameter int RD_LAT = 1
);
  import sp_arb_pkg::*;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          ram_ce, ram_oce, ram_reset, ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din, ram_dout;
`ifdef SP_ARB_STATS_EN
  logic [STAT_W-1:0] stat_conflict, stat_reads;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_reset(ram_reset), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef SP_ARB_STATS_EN
    , .stat_conflict(stat_conflict), .stat_reads(stat_reads)
`endif
  );

  // Behavioural single-port RAM: bypass read register plus optional output register.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout_byp = '0;
  logic [DW-1:0] dout_reg = '0;
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         dout_byp    <= mem[ram_ad];
    end
    if (ram_reset)    dout_reg <= '0;
    else if (ram_oce) dout_reg <= dout_byp;
  end
  assign ram_dout = (RD_LAT == 2) ? dout_reg : dout_byp;

  // Scoreboard: reads pushed at grant, popped when rvalid appears.
  typedef struct {
    bit            own_b;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] shadow [int];
  logic [DW-1:0] got;

  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      checks++;
      if (a_gnt || b_gnt || a_rvalid || b_rvalid || ram_ce || ram_wre || !ram_reset) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b ce=%b wre=%b ram_reset=%b, required 0,0,0,0,0,0,1",
                 a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ce, ram_wre, ram_reset);
      end
    end else begin
      if (a_rvalid || b_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: a_rvalid=%b b_rvalid=%b at cycle %0d, required none", a_rvalid, b_rvalid, cyc);
        end else begin
          e = sb.pop_front();
          got = e.own_b ? b_rdata : a_rdata;
          if ((a_rvalid && b_rvalid) || (b_rvalid !== e.own_b) || (cyc != e.due) || (got !== e.data)) begin
            errors++;
            $display("FAIL read_return: rvalid a/b=%b%b cycle=%0d data=%h, required owner_b=%b cycle=%0d data=%h",
                     a_rvalid, b_rvalid, cyc, got, e.own_b, e.due, e.data);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rvalid: none at cycle %0d, required owner_b=%b due %0d", cyc, sb[0].own_b, sb[0].due);
        void'(sb.pop_front());
      end

      checks++;
      if (a_gnt && b_gnt) begin
        errors++;
        $display("FAIL double_grant: a_gnt=1 b_gnt=1, required at most one");
      end else if (a_gnt || b_gnt) begin
        if (!ram_ce || ram_wre !== (a_gnt ? a_we : b_we) || ram_ad !== (a_gnt ? a_addr : b_addr) ||
            ram_din !== (a_gnt ? a_wdata : b_wdata)) begin
          errors++;
          $display("FAIL ram_drive: ce=%b wre=%b ad=%h din=%h, required winner %s fields", ram_ce, ram_wre, ram_ad,
                   ram_din, a_gnt ? "A" : "B");
        end
        if (a_gnt) begin
          if (a_we) shadow[int'(a_addr)] = a_wdata;
          else sb.push_back('{1'b0, shadow.exists(int'(a_addr)) ? shadow[int'(a_addr)] : '0, cyc + RD_LAT});
        end else begin
          if (b_we) shadow[int'(b_addr)] = b_wdata;
          else sb.push_back('{1'b1, shadow.exists(int'(b_addr)) ? shadow[int'(b_addr)] : '0, cyc + RD_LAT});
        end
      end else if (ram_ce || ram_wre || ram_ad != '0 || ram_din != '0) begin
        errors++;
        $display("FAIL idle_ram: ce=%b wre=%b ad=%h din=%h, required all 0", ram_ce, ram_wre, ram_ad, ram_din);
      end
    end
  end

  task automatic idle();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  // Presents one request and holds it until granted; returns cycles waited.
  task automatic issue(input bit side_b, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, output int waited);
    @(posedge clk); #1;
    idle();
    if (side_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    else        begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    waited = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (side_b ? b_gnt : a_gnt) begin waited = k; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (waited < 0) begin
      errors++;
      $display("FAIL grant_timeout: side_b=%b addr=%h no grant in 8 cycles, required grant", side_b, addr);
    end
  endtask

  task automatic drain();
    int n;
    @(posedge clk); #1;
    idle();
    n = 0;
    while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    a_req = 1; b_req = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || ram_ce !== 1'b0 || ram_oce !== 1'b1) begin
      errors++;
      $display("FAIL test_reset: gnt=%b%b ce=%b oce=%b, required 0,0,0,1", a_gnt, b_gnt, ram_ce, ram_oce);
    end
    @(posedge clk); #1;
    idle();
    reset_n = 1;
  endtask

  task automatic test_write_read();
    int w;
    issue(1'b1, 1'b1, 14'h0010, 32'hDEADBEEF, w);
    issue(1'b0, 1'b0, 14'h0010, 32'h0, w);
    for (int k = 1; k <= RD_LAT; k++) begin
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if (k < RD_LAT) begin
        if (a_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL wr_rd_early: a_rvalid=%b at +%0d, required 0", a_rvalid, k);
        end
      end else if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL wr_rd_return: a_rvalid=%b a_rdata=%h b_rvalid=%b, required 1 deadbeef 0", a_rvalid, a_rdata, b_rvalid);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    logic [DW-1:0] pre [4];
    pre[0] = 32'h11; pre[1] = 32'h22; pre[2] = 32'h33; pre[3] = 32'h44;
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, AW'(i + 1), pre[i], w);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, AW'(i + 1), 32'h0, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL b2b_grant: read %0d waited %0d cycles, required 0", i, w);
      end
    end
    drain();
  endtask

  task automatic test_conflict(input int n);
    do_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      a_req = 1; a_we = 0; a_addr = AW'((i % 4) + 1);
      b_req = 1; b_we = 0; b_addr = 14'h0010;
      @(negedge clk);
      checks++;
      if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL conflict_order: cycle %0d gnt a/b=%b%b, required %b%b", i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1);
      end
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    int w;
    issue(1'b0, 1'b0, 14'h0002, 32'h0, w);
    @(posedge clk); #1;
    reset_n = 0;
    a_req = 1; a_we = 0; a_addr = 14'h0003;
    b_req = 1; b_we = 0; b_addr = 14'h0004;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (a_gnt || b_gnt || a_rvalid || b_rvalid || ram_ce) begin
        errors++;
        $display("FAIL inflight_reset: gnt=%b%b rvalid=%b%b ce=%b, required all 0", a_gnt, b_gnt, a_rvalid, b_rvalid, ram_ce);
      end
    end
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_winner: gnt a/b=%b%b, required 10", a_gnt, b_gnt);
    end
    drain();
  endtask

`ifdef SP_ARB_STATS_EN
  task automatic test_stats();
    test_conflict(5);
    @(negedge clk);
    checks++;
    if (stat_conflict !== 16'd5 || stat_reads !== 16'd5) begin
      errors++;
      $display("FAIL stats: conflict=%0d reads=%0d, required 5 5", stat_conflict, stat_reads);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_conflict(8);
    test_reset_inflight();
`ifdef SP_ARB_STATS_EN
    test_stats();
`endif
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

endmodule
